// File: rtl/pipe_hazard_controller.sv
// Stall/flush/forwarding controller for the five-stage RV32I pipeline.
// It holds the data-memory wait FSM (RUN / MEM_WAIT / FAULT) and a
// saturating stall-cycle counter. All stall, flush and forward outputs are
// combinational from the current state and the stage inputs.
module pipe_hazard_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clock,
  input  logic             async_reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic             mem_read_E,
  input  logic             branch_taken_E,
  input  logic [4:0]       Rd_M,
  input  logic             reg_write_M,
  input  logic             mem_req_M,
  input  logic             dmem_ready,
  input  logic [4:0]       Rd_W,
  input  logic             reg_write_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       forward_A_E,
  output logic [1:0]       forward_B_E,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               mem_stall;
  logic               load_use;

  // Memory wait FSM next state and stall/flush priority: memory > branch > load-use.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_stall = 1'b0;
    stall_F   = 1'b0;
    stall_D   = 1'b0;
    stall_E   = 1'b0;
    stall_M   = 1'b0;
    flush_D   = 1'b0;
    flush_E   = 1'b0;
    flush_W   = 1'b0;
    mem_fault = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_req_M && !dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = StMemWait;
          // The first MEM_WAIT cycle counts as wait cycle 1.
          wait_d    = WaitW'(1);
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_q == WaitW'(TIMEOUT)) begin
            state_d = StFault;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      StFault: begin
        mem_stall = 1'b1;
        mem_fault = 1'b1;
      end
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase

    load_use = mem_read_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    if (mem_stall) begin
      // Whole pipe frozen; a taken branch in E waits in the frozen register.
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (branch_taken_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  // Operand forwarding select, M stage has priority over W.
  always_comb begin
    forward_A_E = 2'b00;
    forward_B_E = 2'b00;
    if (reg_write_M && (Rd_M != 5'd0) && (Rd_M == Rs1_E)) begin
      forward_A_E = 2'b10;
    end else if (reg_write_W && (Rd_W != 5'd0) && (Rd_W == Rs1_E)) begin
      forward_A_E = 2'b01;
    end
    if (reg_write_M && (Rd_M != 5'd0) && (Rd_M == Rs2_E)) begin
      forward_B_E = 2'b10;
    end else if (reg_write_W && (Rd_W != 5'd0) && (Rd_W == Rs2_E)) begin
      forward_B_E = 2'b01;
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_F && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State, wait count and counter registers.
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q        <= StRun;
      wait_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Self-checking bench for pipe_hazard_controller: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
module tb_pipe_hazard_controller;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int          CntMax  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             async_reset;
  logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic             mem_read_E, branch_taken_E, reg_write_M, mem_req_M, dmem_ready;
  logic             reg_write_W;
  logic             stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic [1:0]       forward_A_E, forward_B_E;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: an access is either idle, waiting (with its age in
  // cycles), or has timed out.
  bit m_wait;
  bit m_fault;
  int m_age;
  int m_cnt;

  logic [11:0] obs;
  assign obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                forward_A_E, forward_B_E, mem_fault};

  pipe_hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .async_reset(async_reset),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E),
    .Rd_M(Rd_M), .reg_write_M(reg_write_M), .mem_req_M(mem_req_M),
    .dmem_ready(dmem_ready), .Rd_W(Rd_W), .reg_write_W(reg_write_W),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .mem_fault(mem_fault), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (reg_write_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (reg_write_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] ref_out();
    bit ms, lu;
    logic [6:0] sf;
    ms = m_fault || (m_wait && !dmem_ready) || (!m_wait && mem_req_M && !dmem_ready);
    lu = mem_read_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    if (ms)                  sf = 7'b1111001;
    else if (branch_taken_E) sf = 7'b0000110;
    else if (lu)             sf = 7'b1100010;
    else                     sf = 7'b0000000;
    return {sf, ref_fwd(Rs1_E), ref_fwd(Rs2_E), logic'(m_fault)};
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [11:0] e;
    e = ref_out();
    if (e[11] && m_cnt < CntMax) m_cnt++;
    if (m_fault) begin
      m_fault = 1'b1;
    end else if (m_wait) begin
      if (dmem_ready) m_wait = 1'b0;
      else if (m_age == int'(TIMEOUT)) begin
        m_wait  = 1'b0;
        m_fault = 1'b1;
      end else m_age++;
    end else if (mem_req_M && !dmem_ready) begin
      m_wait = 1'b1;
      m_age  = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
    {mem_read_E, branch_taken_E, reg_write_M, mem_req_M, reg_write_W} = '0;
    dmem_ready = 1'b0;
  endtask

  // Pulse reset between clock edges and reset the model with it.
  task automatic reset_dut();
    clear_inputs();
    async_reset = 1'b1;
    #2;
    async_reset = 1'b0;
    m_wait = 0; m_fault = 0; m_age = 0; m_cnt = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    async_reset = 1'b1;
    #3;
    checks++;
    if (obs !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=000", obs);
    end
    checks++;
    if (stall_cycles !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", stall_cycles);
    end
    async_reset = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    reset_dut();
    Rd_M = 5; reg_write_M = 1; Rd_W = 5; reg_write_W = 1; Rs1_E = 5; Rs2_E = 0;
    #1;
    checks++;
    if (forward_A_E !== 2'b10) begin
      failures++;
      $display("FAIL fwd_m_priority got=%b want=10", forward_A_E);
    end
    Rd_M = 0; Rd_W = 0;
    #1;
    checks++;
    if (forward_B_E !== 2'b00) begin
      failures++;
      $display("FAIL fwd_x0 got=%b want=00", forward_B_E);
    end
    Rd_M = 3; Rd_W = 9; Rs1_E = 9; Rs2_E = 3;
    #1;
    checks++;
    if ({forward_A_E, forward_B_E} !== 4'b0110) begin
      failures++;
      $display("FAIL fwd_w_and_m got=%b want=0110", {forward_A_E, forward_B_E});
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    mem_read_E = 1; Rd_E = 7; Rs2_D = 7;
    #1;
    checks++;
    if (obs[11:5] !== 7'b1100010) begin
      failures++;
      $display("FAIL load_use_stall got=%b want=1100010", obs[11:5]);
    end
    tick();
    mem_read_E = 0; Rd_E = 0; Rd_M = 7; reg_write_M = 1; Rs2_E = 7; Rs2_D = 0;
    #1;
    checks++;
    if ({stall_F, flush_E, forward_B_E} !== 4'b0010) begin
      failures++;
      $display("FAIL load_use_after got=%b want=0010", {stall_F, flush_E, forward_B_E});
    end
    checks++;
    if (stall_cycles !== 1) begin
      failures++;
      $display("FAIL load_use_count got=%0d want=1", stall_cycles);
    end
    mem_read_E = 1; Rd_E = 0; Rs1_D = 0;
    #1;
    checks++;
    if (stall_F !== 1'b0) begin
      failures++;
      $display("FAIL load_use_x0 got=%b want=0", stall_F);
    end
  endtask

  task automatic test_branch_vs_load_use();
    reset_dut();
    mem_read_E = 1; Rd_E = 4; Rs1_D = 4; branch_taken_E = 1;
    #1;
    checks++;
    if (obs[11:5] !== 7'b0000110) begin
      failures++;
      $display("FAIL branch_wins got=%b want=0000110", obs[11:5]);
    end
  endtask

  task automatic test_mem_wait();
    reset_dut();
    mem_req_M = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs[11:5] !== 7'b1111001) begin
        failures++;
        $display("FAIL mem_wait_stall cyc=%0d got=%b want=1111001", i, obs[11:5]);
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (obs[11:5] !== 7'b0000000) begin
      failures++;
      $display("FAIL mem_release got=%b want=0000000", obs[11:5]);
    end
    tick();
    mem_req_M = 0; dmem_ready = 0;
    #1;
    checks++;
    if (stall_F !== 1'b0) begin
      failures++;
      $display("FAIL mem_back_to_run got=%b want=0", stall_F);
    end
    checks++;
    if (stall_cycles !== 3) begin
      failures++;
      $display("FAIL mem_wait_count got=%0d want=3", stall_cycles);
    end
  endtask

  task automatic test_zero_latency();
    reset_dut();
    mem_req_M = 1; dmem_ready = 1;
    repeat (4) tick();
    checks++;
    if ({stall_F, stall_cycles} !== {1'b0, CNT_W'(0)}) begin
      failures++;
      $display("FAIL zero_latency stall=%b cnt=%0d want 0/0", stall_F, stall_cycles);
    end
  endtask

  task automatic test_branch_during_wait();
    reset_dut();
    mem_req_M = 1; dmem_ready = 0; branch_taken_E = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs[11:5] !== 7'b1111001) begin
        failures++;
        $display("FAIL branch_held cyc=%0d got=%b want=1111001", i, obs[11:5]);
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (obs[11:5] !== 7'b0000110) begin
      failures++;
      $display("FAIL branch_release got=%b want=0000110", obs[11:5]);
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    mem_req_M = 1; dmem_ready = 0;
    for (int i = 0; i <= int'(TIMEOUT); i++) begin
      #1;
      checks++;
      if ({mem_fault, stall_F} !== 2'b01) begin
        failures++;
        $display("FAIL timeout_pre cyc=%0d got=%b want=01", i, {mem_fault, stall_F});
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if ({mem_fault, stall_F, flush_W} !== 3'b111) begin
      failures++;
      $display("FAIL timeout_fault got=%b want=111", {mem_fault, stall_F, flush_W});
    end
    #1;
    async_reset = 1'b1;
    #1;
    checks++;
    if ({mem_fault, stall_F, stall_cycles} !== {2'b00, CNT_W'(0)}) begin
      failures++;
      $display("FAIL timeout_async_reset fault=%b stall=%b cnt=%0d want 0/0/0",
               mem_fault, stall_F, stall_cycles);
    end
    async_reset = 1'b0;
    tick();
    #1;
    checks++;
    if (stall_F !== 1'b0) begin
      failures++;
      $display("FAIL timeout_run_after got=%b want=0", stall_F);
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    mem_read_E = 1; Rd_E = 2; Rs1_D = 2;
    repeat (CntMax + 6) tick();
    checks++;
    if (stall_cycles !== CNT_W'(CntMax)) begin
      failures++;
      $display("FAIL count_saturate got=%0d want=%0d", stall_cycles, CntMax);
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    reset_dut();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 160 == 159) reset_dut();
      Rs1_D = 5'($urandom_range(0, 7)); Rs2_D = 5'($urandom_range(0, 7));
      Rs1_E = 5'($urandom_range(0, 7)); Rs2_E = 5'($urandom_range(0, 7));
      Rd_E  = 5'($urandom_range(0, 7)); Rd_M  = 5'($urandom_range(0, 7));
      Rd_W  = 5'($urandom_range(0, 7));
      mem_read_E     = 1'($urandom_range(0, 1));
      branch_taken_E = ($urandom_range(0, 5) == 0);
      reg_write_M    = 1'($urandom_range(0, 1));
      reg_write_W    = 1'($urandom_range(0, 1));
      mem_req_M      = 1'($urandom_range(0, 1));
      dmem_ready     = ($urandom_range(0, 3) != 0);
      #1;
      e = ref_out();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rand_outputs cyc=%0d got=%h want=%h", cyc, obs, e);
      end
      checks++;
      if (stall_cycles !== CNT_W'(m_cnt)) begin
        failures++;
        $display("FAIL rand_count cyc=%0d got=%0d want=%0d", cyc, stall_cycles, m_cnt);
      end
      model_edge();
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    async_reset = 1'b1;
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_zero_latency();
    test_branch_during_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_controller.md
# pipe_hazard_controller

Central stall/flush/forwarding controller for the five-stage RV32I pipeline. Drives the enable (stall) and synchronous-clear (flush) inputs of the F/D/E/M/W pipeline registers and the E-stage operand forwarding muxes. Includes a registered data-memory wait FSM with timeout fault and a saturating stall-cycle performance counter. Sits beside the datapath and observes register indices and control bits from each stage.

## Interface

Parameters:
- TIMEOUT, 255: maximum cycles in MEM_WAIT before fault; legal range 1..65535.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports (name direction width meaning):
- clock  in  1  single clock, rising edge.
- async_reset  in  1  asynchronous, active-high reset.
- Rs1_D, Rs2_D  in  5 each  source registers in decode.
- Rs1_E, Rs2_E  in  5 each  source registers in execute.
- Rd_E  in  5  destination in execute.
- mem_read_E  in  1  E instruction is a load.
- branch_taken_E  in  1  E resolved a taken branch/jump.
- Rd_M, reg_write_M  in  5, 1  M destination and write enable.
- mem_req_M  in  1  M instruction accesses data memory.
- dmem_ready  in  1  data memory completes the M access this cycle.
- Rd_W, reg_write_W  in  5, 1  W destination and write enable.
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold the corresponding pipeline register.
- flush_D, flush_E, flush_W  out  1 each  synchronous clear (bubble) into the corresponding register.
- forward_A_E, forward_B_E  out  2 each  00 register file, 01 from W, 10 from M.
- mem_fault  out  1  sticky timeout fault.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_F=1.

## Operation

- FSM states: RUN, MEM_WAIT, FAULT. State register only; all stall/flush/forward outputs combinational from state and inputs.
- mem_stall = (state==RUN && mem_req_M && !dmem_ready) || (state==MEM_WAIT && !dmem_ready) || state==FAULT.
- mem_stall=1: stall_F=stall_D=stall_E=stall_M=1, flush_W=1, flush_D=flush_E=0. Load-use and branch flush suppressed; a pending branch_taken_E stays held in frozen E and applies after release.
- RUN -> MEM_WAIT when mem_req_M && !dmem_ready. MEM_WAIT -> RUN when dmem_ready (release cycle: no mem stall, W captures M). MEM_WAIT -> FAULT when wait count reaches TIMEOUT with dmem_ready=0. FAULT is terminal until reset; mem_fault=1 in FAULT.
- Wait count: cleared on entry to MEM_WAIT (set to 1 on the RUN->MEM_WAIT edge), +1 per MEM_WAIT cycle; width ceil(log2(TIMEOUT+1)).
- Without mem_stall, branch_taken_E=1: flush_D=flush_E=1, no stalls; wins over load-use.
- Without mem_stall or branch, load-use = mem_read_E && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D): stall_F=stall_D=1, flush_E=1.
- Forwarding (each operand independently): 10 if reg_write_M && Rd_M!=0 && Rd_M==Rs; else 01 if reg_write_W && Rd_W!=0 && Rd_W==Rs; else 00. M has priority. Not gated by stalls.
- stall_cycles += 1 on each clock edge where stall_F=1, saturates at all-ones.

## Timing

- Reset (async, asserted): state=RUN, wait count=0, mem_fault=0, stall_cycles=0. Combinational outputs then follow RUN rules with current inputs.
- Reset mid-MEM_WAIT or in FAULT returns to RUN immediately, no further edge required.
- Zero-latency memory (dmem_ready high with mem_req_M): no stall cycle.
- Access completing N cycles after issue: exactly N stall cycles; state leaves MEM_WAIT on the edge where dmem_ready=1.
- Load-use costs exactly one bubble; next cycle the load is in M and forwarding 10 applies.
- Timeout: FAULT entered on edge after the TIMEOUT-th MEM_WAIT cycle; mem_fault high the following cycle.

## Test plan

- Forwarding: Rd_M=5,reg_write_M=1, Rd_W=5,reg_write_W=1, Rs1_E=5 -> forward_A_E=10; Rd_M=0 with Rs2_E=0 -> forward_B_E=00.
- Load-use: mem_read_E=1, Rd_E=7, Rs2_D=7 -> one cycle stall_F=stall_D=flush_E=1; stall_cycles 0->1.
- Branch vs load-use same cycle: branch_taken_E=1 plus load-use hit -> flush_D=flush_E=1, stall_F=0.
- Memory wait: mem_req_M=1, dmem_ready low 3 cycles then high -> stall_F..stall_M and flush_W high exactly 3 cycles; state RUN afterward; stall_cycles=3.
- Timeout: TIMEOUT=4, dmem_ready held low -> FAULT, mem_fault=1, stalls persist; assert async_reset -> mem_fault=0 and state RUN immediately.
- Branch during memory wait: branch_taken_E=1 while waiting -> no flush until release cycle, then flush_D=flush_E=1.
